// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// counter widths and the load-use detection helper.
package hazard_ctrl_pkg;

    localparam int MD_CNT_W = 4;
    localparam int PERF_W   = 32;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    // A load in EX feeds the instruction in ID; register 0 never creates a dependency.
    function automatic logic is_load_use(
        input logic       exMemread,
        input logic [4:0] exRt,
        input logic [4:0] idRs,
        input logic       idUsesRs,
        input logic [4:0] idRt,
        input logic       idUsesRt
    );
        return exMemread && (exRt != 5'd0) &&
               ((idUsesRs && (idRs == exRt)) || (idUsesRt && (idRt == exRt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The master side is the hazard unit,
// which observes pipeline status and drives stage enables, bubbles and counters.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
();

    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_memread;
    logic [4:0]        ex_rt;
    logic              ex_redirect;
    logic              ex_md_start;
    logic              mem_req;
    logic              dmem_ready;
    logic              perf_clr;

    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              exmem_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    logic              memwb_flush;
    logic              md_done;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_count;

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
               ex_redirect, ex_md_start, mem_req, dmem_ready, perf_clr,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               md_done, stall_cycles, flush_count
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
               ex_redirect, ex_md_start, mem_req, dmem_ready, perf_clr,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               md_done, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Free-running performance counter with synchronous clear; wraps naturally.
module perf_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [PERF_W-1:0] count_o
);

    logic [PERF_W-1:0] count_q;
    logic [PERF_W-1:0] count_d;

    // Clear wins over a same-cycle increment so software sees a clean zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + PERF_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect flushes,
// data-memory wait stalls and a fixed-latency mult/div freeze, plus two
// performance counters (stalled cycles, redirects taken).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4
)
(
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.master bus
);

    // The cycle in RUN that sees ex_md_start and the final md_done cycle are
    // both part of the occupancy, so the wait counter starts two short.
    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LAT - 2);

    state_e              state_q;
    state_e              state_d;
    logic [MD_CNT_W-1:0] mdCnt_q;
    logic [MD_CNT_W-1:0] mdCnt_d;

    logic loadUse;
    logic dmemStall;
    logic redirectTaken;
    logic stallEn;

    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic memwbFlush;
    logic mdDone;

    assign loadUse   = is_load_use(bus.ex_memread, bus.ex_rt, bus.id_rs,
                                   bus.id_uses_rs, bus.id_rt, bus.id_uses_rt);
    assign dmemStall = bus.mem_req & ~bus.dmem_ready;

    // Stage controls by priority: reset, memory wait, mult/div, redirect, load-use.
    always_comb begin
        pcWrite       = 1'b1;
        ifidWrite     = 1'b1;
        idexWrite     = 1'b1;
        exmemWrite    = 1'b1;
        ifidFlush     = 1'b0;
        idexFlush     = 1'b0;
        exmemFlush    = 1'b0;
        memwbFlush    = 1'b0;
        mdDone        = 1'b0;
        redirectTaken = 1'b0;
        if (rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
        end else if (dmemStall) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
        end else if (state_q == RUN) begin
            if (bus.ex_md_start) begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexWrite  = 1'b0;
                exmemFlush = 1'b1;
            end else if (bus.ex_redirect) begin
                ifidFlush     = 1'b1;
                idexFlush     = 1'b1;
                redirectTaken = 1'b1;
            end else if (loadUse) begin
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
                idexFlush = 1'b1;
            end
        end else if (mdCnt_q != '0) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemFlush = 1'b1;
        end else begin
            mdDone = 1'b1;
        end
    end

    // Next state: the wait counter runs down even while memory stalls, but
    // the wait only ends once memory is also free.
    always_comb begin
        state_d = state_q;
        mdCnt_d = mdCnt_q;
        case (state_q)
            RUN: begin
                if (bus.ex_md_start && !dmemStall) begin
                    state_d = MD_WAIT;
                    mdCnt_d = MD_CNT_INIT;
                end
            end
            MD_WAIT: begin
                if (mdCnt_q != '0) begin
                    mdCnt_d = mdCnt_q - MD_CNT_W'(1);
                end else if (!dmemStall) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                mdCnt_d = '0;
            end
        endcase
    end

    // State and wait-counter registers; reset abandons any wait in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            mdCnt_q <= '0;
        end else begin
            state_q <= state_d;
            mdCnt_q <= mdCnt_d;
        end
    end

    assign stallEn = ~rst & ~pcWrite;

    perf_cnt uStallCnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.perf_clr),
        .en_i    (stallEn),
        .count_o (bus.stall_cycles)
    );

    perf_cnt uFlushCnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.perf_clr),
        .en_i    (redirectTaken),
        .count_o (bus.flush_count)
    );

    assign bus.pc_write    = pcWrite;
    assign bus.ifid_write  = ifidWrite;
    assign bus.idex_write  = idexWrite;
    assign bus.exmem_write = exmemWrite;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_flush  = idexFlush;
    assign bus.exmem_flush = exmemFlush;
    assign bus.memwb_flush = memwbFlush;
    assign bus.md_done     = mdDone;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LAT=4). Each stimulus cycle pushes its
// hand-computed expected controls and counter values into a queue; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_hazard_ctrl;

    // Control word order: {pc_write, ifid_write, idex_write, exmem_write,
    //                      ifid_flush, idex_flush, exmem_flush, memwb_flush, md_done}
    localparam logic [8:0] ZERO = 9'b0000_0000_0;
    localparam logic [8:0] DEF  = 9'b1111_0000_0;
    localparam logic [8:0] LU   = 9'b0011_0100_0;
    localparam logic [8:0] MD   = 9'b0001_0010_0;
    localparam logic [8:0] DM   = 9'b0000_0001_0;
    localparam logic [8:0] RD   = 9'b1111_1100_0;
    localparam logic [8:0] DONE = 9'b1111_0000_1;

    typedef struct {
        int          idx;
        logic [8:0]  ctl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic clk;
    logic rst;
    int   numChecks = 0;
    int   numFails  = 0;
    int   vecIdx    = 0;
    exp_t expQ[$];

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MD_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One directed cycle: drive inputs just after the rising edge and queue the expectation.
    task automatic applyStimulus(
        input logic r, input logic [4:0] rs, input logic urs,
        input logic [4:0] rt, input logic urt, input logic mr, input logic [4:0] exRt,
        input logic redir, input logic md, input logic mreq, input logic drdy,
        input logic clr, input logic [8:0] ctl, input logic [31:0] s, input logic [31:0] f
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        hif.id_rs       = rs;
        hif.id_uses_rs  = urs;
        hif.id_rt       = rt;
        hif.id_uses_rt  = urt;
        hif.ex_memread  = mr;
        hif.ex_rt       = exRt;
        hif.ex_redirect = redir;
        hif.ex_md_start = md;
        hif.mem_req     = mreq;
        hif.dmem_ready  = drdy;
        hif.perf_clr    = clr;
        vecIdx++;
        e.idx   = vecIdx;
        e.ctl   = ctl;
        e.stall = s;
        e.flush = f;
        expQ.push_back(e);
    endtask

    task automatic idle(input logic [8:0] ctl, input logic [31:0] s, input logic [31:0] f);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ctl, s, f);
    endtask

    task automatic mdCycle(input logic redir, input logic mreq, input logic drdy,
                           input logic [8:0] ctl, input logic [31:0] s, input logic [31:0] f);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, redir, 1, mreq, drdy, 0, ctl, s, f);
    endtask

    // Preload the stall counter mid-cycle so the wrap and clear paths can be reached.
    task automatic presetStall(input logic [31:0] v);
        #1;
        force dut.uStallCnt.count_q = v;
        #1;
        release dut.uStallCnt.count_q;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [8:0] act;
        act = {hif.pc_write, hif.ifid_write, hif.idex_write, hif.exmem_write,
               hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush, hif.md_done};
        numChecks++;
        if (act !== e.ctl) begin
            numFails++;
            $display("[TB] FAIL ctl vec%0d: got %b expected %b", e.idx, act, e.ctl);
        end
        numChecks++;
        if (hif.stall_cycles !== e.stall) begin
            numFails++;
            $display("[TB] FAIL stall_cycles vec%0d: got %h expected %h", e.idx, hif.stall_cycles, e.stall);
        end
        numChecks++;
        if (hif.flush_count !== e.flush) begin
            numFails++;
            $display("[TB] FAIL flush_count vec%0d: got %h expected %h", e.idx, hif.flush_count, e.flush);
        end
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        hif.id_rs       = '0;
        hif.id_uses_rs  = 1'b0;
        hif.id_rt       = '0;
        hif.id_uses_rt  = 1'b0;
        hif.ex_memread  = 1'b0;
        hif.ex_rt       = '0;
        hif.ex_redirect = 1'b0;
        hif.ex_md_start = 1'b0;
        hif.mem_req     = 1'b0;
        hif.dmem_ready  = 1'b1;
        hif.perf_clr    = 1'b0;

        // Reset: everything quiet even with events requested.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO, 0, 0);
        applyStimulus(1, 5, 1, 0, 0, 1, 5, 1, 1, 0, 1, 0, ZERO, 0, 0);
        idle(DEF, 0, 0);

        // Load-use on rs, then on rt, then rt not used, then register 0.
        applyStimulus(0, 5, 1, 0, 0, 1, 5, 0, 0, 0, 1, 0, LU, 0, 0);
        idle(DEF, 1, 0);
        applyStimulus(0, 3, 1, 7, 1, 1, 7, 0, 0, 0, 1, 0, LU, 1, 0);
        idle(DEF, 2, 0);
        applyStimulus(0, 3, 1, 7, 0, 1, 7, 0, 0, 0, 1, 0, DEF, 2, 0);
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, DEF, 2, 0);
        idle(DEF, 2, 0);

        // Redirect overrides a same-cycle load-use.
        applyStimulus(0, 5, 1, 0, 0, 1, 5, 1, 0, 0, 1, 0, RD, 2, 0);
        idle(DEF, 2, 1);

        // Mult/div: three frozen cycles then md_done.
        mdCycle(0, 0, 1, MD, 2, 1);
        mdCycle(0, 0, 1, MD, 3, 1);
        mdCycle(0, 0, 1, MD, 4, 1);
        mdCycle(0, 0, 1, DONE, 5, 1);
        idle(DEF, 5, 1);

        // Mult/div with redirect: handled as mult/div, redirect not counted.
        mdCycle(1, 0, 1, MD, 5, 1);
        mdCycle(1, 0, 1, MD, 6, 1);
        mdCycle(1, 0, 1, MD, 7, 1);
        mdCycle(1, 0, 1, DONE, 8, 1);
        idle(DEF, 8, 1);

        // Memory stall beats redirect and load-use in RUN.
        applyStimulus(0, 5, 1, 0, 0, 1, 5, 1, 0, 1, 0, 0, DM, 8, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, DEF, 9, 1);

        // Memory stall for six cycles during the wait; md_done waits for memory.
        mdCycle(0, 0, 1, MD, 9, 1);
        mdCycle(0, 1, 0, DM, 10, 1);
        mdCycle(0, 1, 0, DM, 11, 1);
        mdCycle(0, 1, 0, DM, 12, 1);
        mdCycle(0, 1, 0, DM, 13, 1);
        mdCycle(0, 1, 0, DM, 14, 1);
        mdCycle(0, 1, 0, DM, 15, 1);
        mdCycle(0, 1, 1, DONE, 16, 1);
        idle(DEF, 16, 1);

        // Memory stall on the start cycle delays entry into the wait.
        mdCycle(0, 1, 0, DM, 16, 1);
        mdCycle(0, 0, 1, MD, 17, 1);
        mdCycle(0, 0, 1, MD, 18, 1);
        mdCycle(0, 0, 1, MD, 19, 1);
        mdCycle(0, 0, 1, DONE, 20, 1);
        idle(DEF, 20, 1);

        // Reset during the wait: no md_done, back in RUN, counters cleared.
        mdCycle(0, 0, 1, MD, 20, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, ZERO, 21, 1);
        idle(DEF, 0, 0);
        idle(DEF, 0, 0);

        // Stall counter wraps from all ones.
        applyStimulus(0, 5, 1, 0, 0, 1, 5, 0, 0, 0, 1, 0, LU, 32'hFFFF_FFFF, 0);
        presetStall(32'hFFFF_FFFF);
        idle(DEF, 0, 0);

        // Clear beats a same-cycle stall increment.
        applyStimulus(0, 5, 1, 0, 0, 1, 5, 0, 0, 0, 1, 1, LU, 32'hFFFF_FFF0, 0);
        presetStall(32'hFFFF_FFF0);
        idle(DEF, 0, 0);

        // Clear beats a same-cycle redirect count.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, RD, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, RD, 0, 1);
        idle(DEF, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        numChecks++;
        if (expQ.size() != 0) begin
            numFails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4, is the multiply/divide latency in cycles; the legal range is 2..16.
REQ-002 The ports SHALL be as follows:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  id_rs, id_rt  in  5 each  source registers of the instruction in ID
  id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
  ex_memread  in  1  EX instruction is a load
  ex_rt  in  5  load destination in EX
  ex_redirect  in  1  taken branch/jump resolved in EX
  ex_md_start  in  1  mult/div in EX (held while EX is frozen)
  mem_req  in  1  MEM instruction accesses data memory
  dmem_ready  in  1  data memory completes this cycle
  perf_clr  in  1  clear performance counters
  pc_write, ifid_write, idex_write, exmem_write  out  1 each  stage write enables
  ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble inserts
  md_done  out  1  one-cycle pulse when the mult/div wait completes
  stall_cycles  out  32  cycles in which pc_write=0
  flush_count  out  32  number of redirects taken

Function
REQ-003 Two-state FSM, RUN and MD_WAIT, plus a 4-bit down-counter md_cnt; all other outputs SHALL be combinational from state, md_cnt and the current inputs.
REQ-004 load_use = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
REQ-005 dmem_stall = mem_req & ~dmem_ready.
REQ-006 Default (RUN, no event): all write enables are 1 and all flushes are 0.
REQ-007 dmem_stall has highest priority in any state: pc_write, ifid_write, idex_write and exmem_write are 0, memwb_flush is 1, and all other flushes are 0.
REQ-008 In RUN with ex_md_start and no dmem_stall: pc/ifid/idex writes are 0 and exmem_flush is 1; next state is MD_WAIT with md_cnt = MD_LAT-2.
REQ-009 In MD_WAIT, md_cnt SHALL decrement each cycle until it reaches 0, regardless of dmem_stall, and ex_md_start is ignored.
REQ-010 In MD_WAIT with md_cnt!=0 or dmem_stall: hold the outputs of REQ-008, unless REQ-007 applies.
REQ-011 In MD_WAIT with md_cnt==0 and no dmem_stall: default outputs and md_done=1; next state is RUN.
REQ-012 Total EX occupancy of a mult/div with no memory stall SHALL be exactly MD_LAT cycles.
REQ-013 In RUN with ex_redirect, no dmem_stall and no ex_md_start: ifid_flush and idex_flush are 1, pc_write is 1, and load_use is ignored.
REQ-014 ex_md_start and ex_redirect asserted together SHALL be handled as ex_md_start; the redirect is not counted.
REQ-015 In RUN with load_use and no higher-priority event: pc_write and ifid_write are 0, idex_flush is 1, and the remaining writes are 1.
REQ-016 Every flush output SHALL be 0 whenever the corresponding write enable is 0, except where REQ-007, REQ-008 or REQ-015 explicitly assert it.
REQ-017 stall_cycles SHALL increment in every non-reset cycle with pc_write=0.
REQ-018 flush_count SHALL increment on each cycle in which REQ-013 applies.
REQ-019 stall_cycles and flush_count SHALL wrap modulo 2^32.
REQ-020 perf_clr SHALL zero both counters next cycle; perf_clr has priority over a same-cycle increment.

Reset
REQ-021 On rst=1 at a clock edge: state becomes RUN, md_cnt becomes 0, and stall_cycles and flush_count become 0.
REQ-022 While rst=1, every write enable, flush and md_done output SHALL be 0.
REQ-023 Reset asserted in MD_WAIT SHALL abandon the wait with no md_done pulse.

Structure
REQ-024 State encoding (RUN=0, MD_WAIT=1) and the counter width constant SHALL live in the shared pipeline package.
REQ-025 One sub-module, perf_cnt (a 32-bit counter with clear and enable), SHALL be instantiated twice.

Verification
REQ-026 Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1; stall_cycles goes 0->1.
REQ-027 Zero register: same as REQ-026 but ex_rt=0 -> default outputs, no stall.
REQ-028 Mult/div with MD_LAT=4: ex_md_start held -> pc_write=0 for exactly 3 cycles, md_done pulses in the 4th cycle with pc_write=1; stall_cycles=3.
REQ-029 Redirect plus load_use in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1; flush_count=1, stall_cycles=0.
REQ-030 MD_WAIT with dmem_stall held 6 cycles from the 2nd wait cycle -> memwb_flush=1 for those 6 cycles; md_done only after dmem_ready returns; stall_cycles=7.
REQ-031 rst in the 2nd MD_WAIT cycle -> all outputs 0 during rst; RUN afterwards; no md_done; counters 0; perf_clr with stall_cycles=0xFFFFFFFF and a stall -> counter 0.
